hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  one clock; reset is synchronous and active-low.
REQ-003 SHALL have port rs1_id  input  5  source register 1 of instruction in ID.
REQ-004 SHALL have port rs2_id  input  5  source register 2 of instruction in ID.
REQ-005 SHALL have port rd_ex  input  5  destination register of instruction in EX.
REQ-006 SHALL have port MemRd_ex  input  1  EX instruction is a load.
REQ-007 SHALL have port NextPCSrc  input  1  branch/jump taken, resolved in EX.
REQ-008 SHALL have port dmem_req  input  1  ME stage has a data-memory access in flight.
REQ-009 SHALL have port dmem_ready  input  1  data memory completes the access this cycle.
REQ-010 SHALL have outputs stall_pc, stall_ifid, stall_idex, stall_exme  output  1 each  hold PC / pipeline register.
REQ-011 SHALL have outputs flush_ifid, flush_idex  output  1 each  insert bubble into IF/ID / ID/EX.
REQ-012 SHALL have port mem_timeout  output  1  sticky memory-wait watchdog flag.

Function
REQ-013 SHALL implement FSM states RUN and MEM_WAIT, plus registers pend_flush (1b), wait_cnt (8b), mem_timeout (1b).
REQ-014 SHALL drive stall/flush outputs combinationally from current state and inputs (zero-cycle latency); only state/registers are sequential.
REQ-015 load_use SHALL = MemRd_ex && rd_ex!=0 && (rd_ex==rs1_id || rd_ex==rs2_id).
REQ-016 RUN, priority 1: dmem_req && !dmem_ready -> all four stalls=1, flushes=0; next MEM_WAIT, wait_cnt<=0, pend_flush<=NextPCSrc.
REQ-017 RUN, priority 2: NextPCSrc -> flush_ifid=flush_idex=1, all stalls=0; load_use ignored.
REQ-018 RUN, priority 3: load_use -> stall_pc=stall_ifid=1, flush_idex=1, other outputs 0 (single bubble, no state change).
REQ-019 RUN, otherwise: all stall/flush outputs 0.
REQ-020 MEM_WAIT with !dmem_ready: all four stalls=1, flushes=0; pend_flush<=pend_flush|NextPCSrc; wait_cnt increments, saturating at 255.
REQ-021 MEM_WAIT with dmem_ready (release cycle): stalls=0; if pend_flush|NextPCSrc then flush_ifid=flush_idex=1, else apply REQ-018 load-use rule; next RUN, pend_flush<=0.
REQ-022 mem_timeout SHALL set when state==MEM_WAIT, wait_cnt==255 and !dmem_ready; it stays set until reset; FSM keeps waiting.
REQ-023 dmem_ready in the same cycle wait_cnt reaches 255 SHALL win: release, no timeout.
REQ-024 dmem_ready without dmem_req in RUN SHALL be ignored.

Reset
REQ-025 On rising clk with rst_n=0: state<=RUN, pend_flush<=0, wait_cnt<=0, mem_timeout<=0, stall counter<=0.
REQ-026 While rst_n=0 all stall and flush outputs SHALL be 0; reset mid-MEM_WAIT discards pending flush.

Configuration
REQ-027 Macro HAZARD_STATS_EN defined: SHALL add output stall_cnt (32b) counting cycles with stall_pc=1, saturating at 0xFFFFFFFF, cleared by reset.
REQ-028 Macro HAZARD_STATS_EN undefined: stall_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-029 Load-use: MemRd_ex=1, rd_ex=5, rs2_id=5 -> one cycle stall_pc=stall_ifid=flush_idex=1; rd_ex=0 case -> no stall.
REQ-030 Branch vs load-use: NextPCSrc=1 with load_use true -> flush_ifid=flush_idex=1, stall_pc=0.
REQ-031 Memory wait: dmem_req=1, dmem_ready=0 for 4 cycles then 1 -> stalls high exactly 4 cycles, low on release cycle.
REQ-032 Branch during wait: NextPCSrc=1 on first wait cycle only, ready after 3 cycles -> flush_ifid=flush_idex=1 on release cycle only.
REQ-033 Watchdog: dmem_ready held 0 for 300 cycles -> mem_timeout rises after 256th wait cycle, stays 1 after ready, clears only on rst_n=0.
REQ-034 Stats (HAZARD_STATS_EN): 4-cycle wait plus one load-use bubble -> stall_cnt=5; rst_n=0 mid-wait -> outputs 0, stall_cnt=0 next cycle.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX/ME hazard inputs and stall/flush outputs; HAZARD_STATS_EN adds stall_cnt
interface hazard_ctrl_if;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic MemRd_ex, NextPCSrc, dmem_req, dmem_ready;
  logic stall_pc, stall_ifid, stall_idex, stall_exme;
  logic flush_ifid, flush_idex, mem_timeout;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
`endif
  modport master (
    output rs1_id, rs2_id, rd_ex, MemRd_ex, NextPCSrc, dmem_req, dmem_ready,
    input stall_pc, stall_ifid, stall_idex, stall_exme, flush_ifid, flush_idex, mem_timeout
`ifdef HAZARD_STATS_EN
    , stall_cnt
`endif
  );
  modport slave (
    input rs1_id, rs2_id, rd_ex, MemRd_ex, NextPCSrc, dmem_req, dmem_ready,
    output stall_pc, stall_ifid, stall_idex, stall_exme, flush_ifid, flush_idex, mem_timeout
`ifdef HAZARD_STATS_EN
    , stall_cnt
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control with memory-wait FSM and watchdog; HAZARD_STATS_EN adds stall_cnt
module hazard_ctrl (
  input logic clk,
  input logic rst_n,
  hazard_ctrl_if.slave bus
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t r_state, w_next;
  logic r_pend, r_timeout;
  logic [7:0] r_wait_cnt;
  logic w_load_use, w_stall_all, w_stall_front, w_flush_if, w_flush_id;
  always_comb begin
    w_load_use = bus.MemRd_ex && bus.rd_ex != 5'd0 && (bus.rd_ex == bus.rs1_id || bus.rd_ex == bus.rs2_id);
    w_next = r_state;
    w_stall_all = 1'b0;
    w_stall_front = 1'b0;
    w_flush_if = 1'b0;
    w_flush_id = 1'b0;
    if (r_state == RUN) begin
      if (bus.dmem_req && !bus.dmem_ready) begin
        w_stall_all = 1'b1;
        w_next = MEM_WAIT;
      end else if (bus.NextPCSrc) begin
        w_flush_if = 1'b1;
        w_flush_id = 1'b1;
      end else if (w_load_use) begin
        w_stall_front = 1'b1;
        w_flush_id = 1'b1;
      end
    end else if (!bus.dmem_ready) begin
      w_stall_all = 1'b1;
    end else begin
      w_next = RUN;
      w_flush_if = r_pend || bus.NextPCSrc;
      w_flush_id = r_pend || bus.NextPCSrc || w_load_use;
      w_stall_front = !(r_pend || bus.NextPCSrc) && w_load_use;
    end
  end
  assign bus.stall_pc = rst_n && (w_stall_all || w_stall_front);
  assign bus.stall_ifid = rst_n && (w_stall_all || w_stall_front);
  assign bus.stall_idex = rst_n && w_stall_all;
  assign bus.stall_exme = rst_n && w_stall_all;
  assign bus.flush_ifid = rst_n && w_flush_if;
  assign bus.flush_idex = rst_n && w_flush_id;
  assign bus.mem_timeout = r_timeout;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_pend <= 1'b0;
      r_wait_cnt <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pend <= (w_next == MEM_WAIT) && ((r_state == MEM_WAIT && r_pend) || bus.NextPCSrc);
      r_wait_cnt <= (r_state == MEM_WAIT && w_next == MEM_WAIT) ? r_wait_cnt + 8'(r_wait_cnt != 8'hFF) : 8'd0;
      if (r_state == MEM_WAIT && r_wait_cnt == 8'hFF && !bus.dmem_ready) r_timeout <= 1'b1;
    end
  end
`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) r_stall_cnt <= 32'd0;
    else r_stall_cnt <= r_stall_cnt + 32'(bus.stall_pc && r_stall_cnt != 32'hFFFF_FFFF);
  end
  assign bus.stall_cnt = r_stall_cnt;
`else
`endif
endmodule
